// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, ALU flag bit positions, ALUCon opcodes,
// EX/MEM trap FSM states and the MEM/WB control bundle.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_FLAG_W = 3;
  localparam int MIPS_REG_W  = 5;

  // Bit positions inside the ALU Flag vector {underflow, overflow, div-by-zero}
  localparam int FLAG_DIVZ = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_UNF  = 2;

  localparam logic [3:0] ALUCON_AND = 4'b0000;
  localparam logic [3:0] ALUCON_OR  = 4'b0001;
  localparam logic [3:0] ALUCON_ADD = 4'b0010;
  localparam logic [3:0] ALUCON_MUL = 4'b0011;
  localparam logic [3:0] ALUCON_DIV = 4'b0100;
  localparam logic [3:0] ALUCON_SUB = 4'b0110;
  localparam logic [3:0] ALUCON_SLT = 4'b0111;
  localparam logic [3:0] ALUCON_NOR = 4'b1100;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } ex_mem_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_mem_ctrl_t;

  localparam ex_mem_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ex_mem_trap_fsm.sv
// RUN/TRAP controller for the EX/MEM register: detects ALU faults, latches EPC/cause,
// emits the one-cycle entry pulse and tells the datapath when to squash.
module ex_mem_trap_fsm #(
  parameter int DATA_W = mips_pkg::MIPS_DATA_W,
  parameter int FLAG_W = mips_pkg::MIPS_FLAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              exc_ack_i,
  input  logic              ex_valid_i,
  input  logic [FLAG_W-1:0] ex_flag_i,
  input  logic [DATA_W-1:0] ex_pc_i,
  output logic              squash_o,
  output logic              exc_pulse_o,
  output logic              exc_pending_o,
  output logic [DATA_W-1:0] epc_o,
  output logic [FLAG_W-1:0] cause_o
);
  import mips_pkg::*;

  ex_mem_state_t state, state_next;
  logic          trap_entry;

  // A fault only counts on an edge that actually captures the instruction.
  assign trap_entry = (state == RUN) && ex_valid_i && (ex_flag_i != '0)
                      && !stall_i && !flush_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_next = state;
    case (state)
      RUN:     if (trap_entry) state_next = TRAP;
      TRAP:    if (exc_ack_i)  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Squash covers the faulting instruction itself and everything captured while trapped,
  // including the instruction on the acknowledging edge.
  assign squash_o      = (state == TRAP) || trap_entry;
  assign exc_pending_o = (state == TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      exc_pulse_o <= 1'b0;
      epc_o       <= '0;
      cause_o     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state       <= state_next;
      exc_pulse_o <= trap_entry;
      if (trap_entry) begin
        epc_o   <= ex_pc_i;
        cause_o <= ex_flag_i;
      end
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: holds ALU result, store data, destination and MEM/WB controls,
// with stall, flush, overflow trap squash and the MEM-stage forwarding qualifier.
module ex_mem_reg #(
  parameter int DATA_W = mips_pkg::MIPS_DATA_W,
  parameter int FLAG_W = mips_pkg::MIPS_FLAG_W,
  parameter int REG_W  = mips_pkg::MIPS_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              exc_ack_i,
  input  logic              ex_valid_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [FLAG_W-1:0] ex_flag_i,
  input  logic [DATA_W-1:0] ex_store_data_i,
  input  logic [REG_W-1:0]  ex_write_reg_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_mem_write_i,
  input  logic              ex_mem_to_reg_i,
  input  logic [DATA_W-1:0] ex_pc_i,
  output logic              mem_valid_o,
  output logic [DATA_W-1:0] mem_result_o,
  output logic [DATA_W-1:0] mem_store_data_o,
  output logic [REG_W-1:0]  mem_write_reg_o,
  output logic              mem_reg_write_o,
  output logic              mem_mem_read_o,
  output logic              mem_mem_write_o,
  output logic              mem_mem_to_reg_o,
  output logic              fwd_valid_o,
  output logic              exc_pulse_o,
  output logic              exc_pending_o,
  output logic [DATA_W-1:0] epc_o,
  output logic [FLAG_W-1:0] cause_o
);
  import mips_pkg::*;

  ex_mem_ctrl_t ex_ctrl, mem_ctrl;
  logic         squash;

  assign ex_ctrl = '{reg_write:  ex_reg_write_i,
                     mem_read:   ex_mem_read_i,
                     mem_write:  ex_mem_write_i,
                     mem_to_reg: ex_mem_to_reg_i};

  ex_mem_trap_fsm #(
    .DATA_W(DATA_W),
    .FLAG_W(FLAG_W)
  ) u_trap_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .exc_ack_i    (exc_ack_i),
    .ex_valid_i   (ex_valid_i),
    .ex_flag_i    (ex_flag_i),
    .ex_pc_i      (ex_pc_i),
    .squash_o     (squash),
    .exc_pulse_o  (exc_pulse_o),
    .exc_pending_o(exc_pending_o),
    .epc_o        (epc_o),
    .cause_o      (cause_o)
  );

  // Flush wins over stall; a squashed instruction becomes a full bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_o      <= 1'b0;
      mem_result_o     <= '0;
      mem_store_data_o <= '0;
      mem_write_reg_o  <= '0;
      mem_ctrl         <= CTRL_NOP;
    end else if (flush_i || (!stall_i && squash)) begin
      mem_valid_o      <= 1'b0;
      mem_result_o     <= '0;
      mem_store_data_o <= '0;
      mem_write_reg_o  <= '0;
      mem_ctrl         <= CTRL_NOP;
    end else if (!stall_i) begin
      mem_valid_o      <= ex_valid_i;
      mem_result_o     <= ex_result_i;
      mem_store_data_o <= ex_store_data_i;
      mem_write_reg_o  <= ex_write_reg_i;
      mem_ctrl         <= ex_ctrl;
    end
  end

  assign mem_reg_write_o  = mem_ctrl.reg_write;
  assign mem_mem_read_o   = mem_ctrl.mem_read;
  assign mem_mem_write_o  = mem_ctrl.mem_write;
  assign mem_mem_to_reg_o = mem_ctrl.mem_to_reg;

  // $zero is never a forwarding source.
  assign fwd_valid_o = mem_valid_o && mem_reg_write_o && (mem_write_reg_o != '0);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: per-scenario tasks, expected outputs queued when a
// vector is driven and popped for comparison after the capturing edge.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, exc_ack_i;
  logic        ex_valid_i;
  logic [31:0] ex_result_i, ex_store_data_i, ex_pc_i;
  logic [2:0]  ex_flag_i;
  logic [4:0]  ex_write_reg_i;
  logic        ex_reg_write_i, ex_mem_read_i, ex_mem_write_i, ex_mem_to_reg_i;
  logic        mem_valid_o;
  logic [31:0] mem_result_o, mem_store_data_o;
  logic [4:0]  mem_write_reg_o;
  logic        mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o;
  logic        fwd_valid_o, exc_pulse_o, exc_pending_o;
  logic [31:0] epc_o;
  logic [2:0]  cause_o;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] sdata;
    logic [4:0]  wreg;
    logic [3:0]  ctrl;   // {reg_write, mem_read, mem_write, mem_to_reg}
    logic        fwd;
    logic        pulse;
    logic        pending;
    logic [31:0] epc;
    logic [2:0]  cause;
  } obs_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] sdata;
    logic [4:0]  wreg;
    logic [3:0]  ctrl;
    logic [31:0] pc;
    logic [2:0]  flag;
  } in_t;

  typedef struct {
    in_t  in;
    logic stall;
    logic flush;
    logic ack;
    obs_t exp;
  } vec_t;

  obs_t exp_q[$];

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .exc_ack_i(exc_ack_i),
    .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i), .ex_flag_i(ex_flag_i),
    .ex_store_data_i(ex_store_data_i), .ex_write_reg_i(ex_write_reg_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_mem_write_i(ex_mem_write_i), .ex_mem_to_reg_i(ex_mem_to_reg_i), .ex_pc_i(ex_pc_i),
    .mem_valid_o(mem_valid_o), .mem_result_o(mem_result_o),
    .mem_store_data_o(mem_store_data_o), .mem_write_reg_o(mem_write_reg_o),
    .mem_reg_write_o(mem_reg_write_o), .mem_mem_read_o(mem_mem_read_o),
    .mem_mem_write_o(mem_mem_write_o), .mem_mem_to_reg_o(mem_mem_to_reg_o),
    .fwd_valid_o(fwd_valid_o), .exc_pulse_o(exc_pulse_o), .exc_pending_o(exc_pending_o),
    .epc_o(epc_o), .cause_o(cause_o)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(logic v, logic [31:0] res, logic [31:0] sd, logic [4:0] wr,
                                logic [3:0] ctrl, logic [31:0] pc, logic [2:0] flag);
    in_t i;
    i = '{valid: v, result: res, sdata: sd, wreg: wr, ctrl: ctrl, pc: pc, flag: flag};
    return i;
  endfunction

  function automatic obs_t mk_obs(logic v, logic [31:0] res, logic [31:0] sd, logic [4:0] wr,
                                  logic [3:0] ctrl, logic fwd, logic pulse, logic pend,
                                  logic [31:0] epc, logic [2:0] cause);
    obs_t o;
    o = '{valid: v, result: res, sdata: sd, wreg: wr, ctrl: ctrl, fwd: fwd, pulse: pulse,
          pending: pend, epc: epc, cause: cause};
    return o;
  endfunction

  function automatic obs_t bubble(logic pulse, logic pend, logic [31:0] epc, logic [2:0] cause);
    return mk_obs(1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, pulse, pend, epc, cause);
  endfunction

  function automatic vec_t mk_vec(in_t i, logic st, logic fl, logic ak, obs_t e);
    vec_t v;
    v.in = i; v.stall = st; v.flush = fl; v.ack = ak; v.exp = e;
    return v;
  endfunction

  function automatic obs_t observe();
    return mk_obs(mem_valid_o, mem_result_o, mem_store_data_o, mem_write_reg_o,
                  {mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o},
                  fwd_valid_o, exc_pulse_o, exc_pending_o, epc_o, cause_o);
  endfunction

  // Drive one vector, queue its expectation, and advance to just after the capturing edge.
  task automatic drive_vec(input vec_t v);
    ex_valid_i      = v.in.valid;
    ex_result_i     = v.in.result;
    ex_store_data_i = v.in.sdata;
    ex_write_reg_i  = v.in.wreg;
    {ex_reg_write_i, ex_mem_read_i, ex_mem_write_i, ex_mem_to_reg_i} = v.in.ctrl;
    ex_pc_i         = v.in.pc;
    ex_flag_i       = v.in.flag;
    stall_i         = v.stall;
    flush_i         = v.flush;
    exc_ack_i       = v.ack;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    drive_vec(mk_vec(mk_in(1, 32'h1111_1111, 32'h2222_2222, 5'd7, 4'b1111, 32'h0040_0000, 3'b010),
                     0, 0, 0, '0));
    got = observe();
    tests_run++;
    if (got !== exp_q.pop_front()) begin
      tests_failed++;
      $display("FAIL reset: got %h, expected all zero", got);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_and_compare(input string tag, input vec_t v[$]);
    obs_t got, want;
    for (int k = 0; k < v.size(); k++) begin
      drive_vec(v[k]);
      got  = observe();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %h, expected %h", tag, k, got, want);
      end
    end
  endtask

  task automatic test_normal();
    vec_t v[$];
    v.push_back(mk_vec(mk_in(1, 32'h0000_0005, 32'h0000_1234, 5'd8, 4'b1000, 32'h0040_0000, 3'b000),
                       0, 0, 0, mk_obs(1, 32'h5, 32'h1234, 5'd8, 4'b1000, 1, 0, 0, 32'h0, 3'b0)));
    // Load word; ack while running is ignored.
    v.push_back(mk_vec(mk_in(1, 32'h1000_0040, 32'h0, 5'd9, 4'b1101, 32'h0040_0004, 3'b000),
                       0, 0, 1, mk_obs(1, 32'h1000_0040, 32'h0, 5'd9, 4'b1101, 1, 0, 0, 32'h0, 3'b0)));
    run_and_compare("normal", v);
  endtask

  task automatic test_stall_flush();
    vec_t v[$];
    obs_t held;
    held = mk_obs(1, 32'h1000_0040, 32'h0, 5'd9, 4'b1101, 1, 0, 0, 32'h0, 3'b0);
    v.push_back(mk_vec(mk_in(1, 32'h0000_dead, 32'h0000_beef, 5'd3, 4'b1000, 32'h0040_0008, 3'b000),
                       1, 0, 0, held));
    v.push_back(mk_vec(mk_in(0, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0040_000c, 3'b000), 1, 0, 0, held));
    // A fault seen under stall must not start a trap.
    v.push_back(mk_vec(mk_in(1, 32'h8000_0000, 32'h0, 5'd4, 4'b1000, 32'h0040_0008, 3'b010),
                       1, 0, 0, held));
    v.push_back(mk_vec(mk_in(1, 32'h0000_0006, 32'h7, 5'd6, 4'b1101, 32'h0040_0008, 3'b000),
                       1, 1, 0, bubble(0, 0, 32'h0, 3'b0)));
    v.push_back(mk_vec(mk_in(1, 32'h8000_0000, 32'h0, 5'd4, 4'b1000, 32'h0040_0008, 3'b010),
                       0, 1, 0, bubble(0, 0, 32'h0, 3'b0)));
    v.push_back(mk_vec(mk_in(1, 32'h0000_0007, 32'h0, 5'd2, 4'b1000, 32'h0040_000c, 3'b000),
                       0, 0, 0, mk_obs(1, 32'h7, 32'h0, 5'd2, 4'b1000, 1, 0, 0, 32'h0, 3'b0)));
    run_and_compare("stall_flush", v);
  endtask

  task automatic test_overflow();
    vec_t v[$];
    v.push_back(mk_vec(mk_in(1, 32'h8000_0000, 32'h55, 5'd10, 4'b1000, 32'h0040_0010, 3'b010),
                       0, 0, 0, bubble(1, 1, 32'h0040_0010, 3'b010)));
    v.push_back(mk_vec(mk_in(0, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0040_0014, 3'b000),
                       0, 0, 0, bubble(0, 1, 32'h0040_0010, 3'b010)));
    run_and_compare("overflow", v);
  endtask

  task automatic test_trap_hold();
    vec_t v[$];
    v.push_back(mk_vec(mk_in(1, 32'h1000_0000, 32'h0000_aaaa, 5'd0, 4'b0010, 32'h0040_0014, 3'b000),
                       0, 0, 0, bubble(0, 1, 32'h0040_0010, 3'b010)));
    v.push_back(mk_vec(mk_in(1, 32'h1000_0004, 32'h0000_bbbb, 5'd0, 4'b0010, 32'h0040_0018, 3'b001),
                       0, 0, 0, bubble(0, 1, 32'h0040_0010, 3'b010)));
    v.push_back(mk_vec(mk_in(1, 32'h0000_0009, 32'h0, 5'd11, 4'b1000, 32'h0040_001c, 3'b000),
                       0, 0, 1, bubble(0, 0, 32'h0040_0010, 3'b010)));
    v.push_back(mk_vec(mk_in(1, 32'h0000_0020, 32'h0, 5'd12, 4'b1000, 32'h0040_0020, 3'b000),
                       0, 0, 0, mk_obs(1, 32'h20, 32'h0, 5'd12, 4'b1000, 1, 0, 0, 32'h0040_0010, 3'b010)));
    run_and_compare("trap_hold", v);
  endtask

  task automatic test_ack_under_stall();
    vec_t v[$];
    v.push_back(mk_vec(mk_in(1, 32'h7fff_ffff, 32'h0, 5'd13, 4'b1000, 32'h0040_0100, 3'b100),
                       0, 0, 0, bubble(1, 1, 32'h0040_0100, 3'b100)));
    v.push_back(mk_vec(mk_in(1, 32'h0000_0031, 32'h0, 5'd14, 4'b1000, 32'h0040_0104, 3'b000),
                       1, 0, 1, bubble(0, 0, 32'h0040_0100, 3'b100)));
    v.push_back(mk_vec(mk_in(1, 32'h0000_0030, 32'h1, 5'd14, 4'b1000, 32'h0040_0108, 3'b000),
                       0, 0, 0, mk_obs(1, 32'h30, 32'h1, 5'd14, 4'b1000, 1, 0, 0, 32'h0040_0100, 3'b100)));
    run_and_compare("ack_stall", v);
  endtask

  task automatic test_reset_mid_trap();
    vec_t v[$];
    vec_t w[$];
    obs_t got;
    v.push_back(mk_vec(mk_in(1, 32'h0000_0001, 32'h0, 5'd15, 4'b1000, 32'h0040_0200, 3'b001),
                       0, 0, 0, bubble(1, 1, 32'h0040_0200, 3'b001)));
    run_and_compare("enter_trap", v);
    #2 rst_n = 1'b0;
    #1;
    got = observe();
    tests_run++;
    if (got !== obs_t'(0)) begin
      tests_failed++;
      $display("FAIL async_reset_mid_trap: got %h, expected all zero", got);
    end
    #2 rst_n = 1'b1;
    w.push_back(mk_vec(mk_in(1, 32'h0000_0044, 32'h0, 5'd16, 4'b1000, 32'h0040_0210, 3'b000),
                       0, 0, 0, mk_obs(1, 32'h44, 32'h0, 5'd16, 4'b1000, 1, 0, 0, 32'h0, 3'b0)));
    run_and_compare("after_reset", w);
  endtask

  task automatic test_zero_dest();
    vec_t v[$];
    v.push_back(mk_vec(mk_in(1, 32'h0000_0099, 32'h0, 5'd0, 4'b1000, 32'h0040_0214, 3'b000),
                       0, 0, 0, mk_obs(1, 32'h99, 32'h0, 5'd0, 4'b1000, 0, 0, 0, 32'h0, 3'b0)));
    v.push_back(mk_vec(mk_in(1, 32'h0000_0098, 32'h3, 5'd5, 4'b0010, 32'h0040_0218, 3'b000),
                       0, 0, 0, mk_obs(1, 32'h98, 32'h3, 5'd5, 4'b0010, 0, 0, 0, 32'h0, 3'b0)));
    run_and_compare("zero_dest", v);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall_flush();
    test_overflow();
    test_trap_hold();
    test_ack_under_stall();
    test_reset_mid_trap();
    test_zero_dest();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
